// File: rtl/token_queue_writer_if.sv
// Token queue writer bus: input beat stream plus token queue write port.
// master = environment (parser front end + queue), slave = token_queue_writer.
interface token_queue_writer_if #(
    parameter int ADDR_W = 17
);
    // Beat stream from the parser front end
    logic [127:0]      in_data;
    logic [15:0]       in_position;
    logic [1:0]        in_garbage;
    logic              in_lit_flag;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;

    // Token queue write port
    logic              q_wrreq;
    logic [143:0]      q_data;
    logic [15:0]       q_position;
    logic [ADDR_W-1:0] q_address;
    logic [1:0]        q_garbage;
    logic              q_lit_flag;
    logic              q_almost_full;

    modport master (
        output in_data,
        output in_position,
        output in_garbage,
        output in_lit_flag,
        output in_last,
        output in_valid,
        input  in_ready,
        input  q_wrreq,
        input  q_data,
        input  q_position,
        input  q_address,
        input  q_garbage,
        input  q_lit_flag,
        output q_almost_full
    );

    modport slave (
        input  in_data,
        input  in_position,
        input  in_garbage,
        input  in_lit_flag,
        input  in_last,
        input  in_valid,
        output in_ready,
        output q_wrreq,
        output q_data,
        output q_position,
        output q_address,
        output q_garbage,
        output q_lit_flag,
        input  q_almost_full
    );
endinterface

// File: rtl/token_queue_writer.sv
// Producer side of the token queue. Each 16-byte beat is held until the next
// beat arrives so its first 2 bytes can be appended as lookahead; the last beat
// of a stream is flushed with a zero lookahead. Entries carry a running byte
// address (modulo 2^ADDR_W) and are written under prog-full backpressure.
// Optional: define TOKEN_WR_COUNT_EN to add the saturating wr_count output.
module token_queue_writer #(
    parameter int BEAT_BYTES = 16,
    parameter int ADDR_W     = 17
) (
    input  logic                 clk,
    input  logic                 rst,
    token_queue_writer_if.slave  bus,
    output logic                 done
`ifdef TOKEN_WR_COUNT_EN
    ,
    output logic [31:0]          wr_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BEAT_BYTES);

    state_t            state;
    state_t            state_nx;

    logic              ready;
    logic              accept;
    logic              emit_pair;
    logic              emit_flush;

    logic [127:0]      pend_data;
    logic [15:0]       pend_position;
    logic [1:0]        pend_garbage;
    logic              pend_lit_flag;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] addr_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: advance on accepted beats, leave FLUSH once the last entry is written
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx = bus.in_last ? FLUSH : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    state_nx = bus.in_last ? FLUSH : HOLD;
                end
            end
            FLUSH: begin
                if (emit_flush) begin
                    state_nx = EMPTY;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // Handshake and write decisions; backpressure stalls input in the same cycle
    always_comb begin
        ready      = ~rst & ~bus.q_almost_full & (state != FLUSH);
        accept     = bus.in_valid & ready;
        emit_pair  = accept & (state == HOLD);
        emit_flush = ~rst & ~bus.q_almost_full & (state == FLUSH);
    end

    assign bus.in_ready = ready;

    // Pending beat and running address; a flush restarts addressing for the next stream
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data     <= '0;
            pend_position <= '0;
            pend_garbage  <= '0;
            pend_lit_flag <= 1'b0;
            pend_addr     <= '0;
            addr_cnt      <= '0;
        end else if (accept) begin
            pend_data     <= bus.in_data;
            pend_position <= bus.in_position;
            pend_garbage  <= bus.in_garbage;
            pend_lit_flag <= bus.in_lit_flag;
            pend_addr     <= addr_cnt;
            addr_cnt      <= addr_cnt + ADDR_STEP;
        end else if (emit_flush) begin
            addr_cnt      <= '0;
        end
    end

    // Registered queue write port: pending beat plus lookahead from the incoming beat
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.q_wrreq    <= 1'b0;
            bus.q_data     <= '0;
            bus.q_position <= '0;
            bus.q_address  <= '0;
            bus.q_garbage  <= '0;
            bus.q_lit_flag <= 1'b0;
            done           <= 1'b0;
        end else begin
            bus.q_wrreq <= emit_pair | emit_flush;
            done        <= emit_flush;
            if (emit_pair) begin
                bus.q_data     <= {pend_data, bus.in_data[127:112]};
                bus.q_position <= pend_position;
                bus.q_address  <= pend_addr;
                bus.q_garbage  <= pend_garbage;
                bus.q_lit_flag <= pend_lit_flag;
            end else if (emit_flush) begin
                bus.q_data     <= {pend_data, 16'h0000};
                bus.q_position <= pend_position;
                bus.q_address  <= pend_addr;
                bus.q_garbage  <= pend_garbage;
                bus.q_lit_flag <= pend_lit_flag;
            end
        end
    end

`ifdef TOKEN_WR_COUNT_EN
    // Lifetime write counter, saturating; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (bus.q_wrreq && (wr_count != '1)) begin
            wr_count <= wr_count + 32'd1;
        end
    end
`endif

    // done only ever accompanies the final write of a stream
    a_done_with_write: assert property (@(posedge clk) disable iff (rst) done |-> bus.q_wrreq);

    // Nothing is written while the queue reports prog-full in FLUSH
    a_no_flush_when_full: assert property (@(posedge clk) disable iff (rst)
        (state == FLUSH && bus.q_almost_full) |=> !done);

endmodule

// File: tb/tb_token_queue_writer.sv
// Directed self-checking bench for token_queue_writer.
module tb_token_queue_writer;

    typedef struct packed {
        logic [143:0] data;
        logic [15:0]  pos;
        logic [16:0]  addr;
        logic [1:0]   garb;
        logic         lit;
        logic         done;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic done;
`ifdef TOKEN_WR_COUNT_EN
    logic [31:0] wr_count;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stray_done = 0;
    ent_t cap[$];
    int   cap_cyc[$];

    token_queue_writer_if #(.ADDR_W(17)) bus ();

    token_queue_writer #(.BEAT_BYTES(16), .ADDR_W(17)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .done (done)
`ifdef TOKEN_WR_COUNT_EN
        ,
        .wr_count (wr_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every queue write away from the active edge
    always @(negedge clk) begin
        if (bus.q_wrreq === 1'b1) begin
            cap.push_back({bus.q_data, bus.q_position, bus.q_address, bus.q_garbage, bus.q_lit_flag, done});
            cap_cyc.push_back(cyc);
        end
        if (done === 1'b1 && bus.q_wrreq !== 1'b1) stray_done++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mk_beat(input int unsigned s);
        logic [127:0] b;
        b[127:120] = s[7:0];
        b[119:112] = s[15:8];
        for (int k = 2; k < 16; k++) b[127-8*k -: 8] = 8'(s * 3 + k);
        return b;
    endfunction

    function automatic ent_t mk_ent(input logic [143:0] d, input logic [15:0] p, input logic [16:0] a,
                                    input logic [1:0] g, input logic l, input logic dn);
        ent_t e;
        e.data = d; e.pos = p; e.addr = a; e.garb = g; e.lit = l; e.done = dn;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Present a beat and hold it until accepted (bounded); leaves in_valid high
    task automatic drive_beat(input logic [127:0] d, input logic [15:0] p, input logic [1:0] g,
                              input logic l, input logic last, output bit acc);
        bus.in_data     = d;
        bus.in_position = p;
        bus.in_garbage  = g;
        bus.in_lit_flag = l;
        bus.in_last     = last;
        bus.in_valid    = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            #1;
            if (bus.in_ready === 1'b1) acc = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.q_almost_full = 1'b0;
        bus.in_data = '0; bus.in_position = '0; bus.in_garbage = '0; bus.in_lit_flag = 1'b0;
        tick(2);
        total++;
        if (bus.q_wrreq !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_strobes: wrreq=%b done=%b required 0 0", bus.q_wrreq, done);
        end
        total++;
        if ({bus.q_data, bus.q_position, bus.q_address, bus.q_garbage, bus.q_lit_flag} !== '0) begin
            bad++; $display("FAIL reset_fields: data=%h pos=%h addr=%h required all zero", bus.q_data, bus.q_position, bus.q_address);
        end
        bus.in_valid = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready: in_ready=%b required 0", bus.in_ready);
        end
        tick(1);
        idle();
        rst = 1'b0;
        tick(1);
        total++;
        if (cap.size() != 0) begin
            bad++; $display("FAIL reset_no_write: writes=%0d required 0", cap.size());
        end
    endtask

    task automatic test_three_beats();
        logic [127:0] a, b, c;
        ent_t exp[3];
        bit acc, all_acc;
        a = mk_beat(32'h0100); b = mk_beat(32'h0200); c = mk_beat(32'h0300);
        exp[0] = mk_ent({a, b[127:112]}, 16'h1234, 17'h00000, 2'd1, 1'b0, 1'b0);
        exp[1] = mk_ent({b, c[127:112]}, 16'hA5A5, 17'h00010, 2'd2, 1'b1, 1'b0);
        exp[2] = mk_ent({c, 16'h0000},   16'h0F0F, 17'h00020, 2'd3, 1'b0, 1'b1);
        cap.delete(); cap_cyc.delete();
        all_acc = 1'b1;
        drive_beat(a, 16'h1234, 2'd1, 1'b0, 1'b0, acc); all_acc &= acc;
        drive_beat(b, 16'hA5A5, 2'd2, 1'b1, 1'b0, acc); all_acc &= acc;
        drive_beat(c, 16'h0F0F, 2'd3, 1'b0, 1'b1, acc); all_acc &= acc;
        idle();
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_ready: in_ready=%b required 0", bus.in_ready);
        end
        tick(4);
        total++;
        if (!all_acc || cap.size() != 3) begin
            bad++; $display("FAIL three_count: accepted=%b writes=%0d required 1 3", all_acc, cap.size());
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= cap.size()) begin
                bad++; $display("FAIL three_entry%0d: missing, required %h", i, exp[i]);
            end else if (cap[i] !== exp[i]) begin
                bad++; $display("FAIL three_entry%0d: got %h required %h", i, cap[i], exp[i]);
            end
        end
        total++;
        if (cap.size() == 3 && (cap_cyc[1] != cap_cyc[0] + 1 || cap_cyc[2] != cap_cyc[1] + 1)) begin
            bad++; $display("FAIL back_to_back: cycles %0d %0d %0d required consecutive", cap_cyc[0], cap_cyc[1], cap_cyc[2]);
        end
    endtask

    task automatic test_single_beat();
        logic [127:0] d;
        ent_t exp;
        bit acc;
        d = mk_beat(32'h0BEE);
        exp = mk_ent({d, 16'h0000}, 16'h8001, 17'h00000, 2'd2, 1'b1, 1'b1);
        cap.delete(); cap_cyc.delete();
        drive_beat(d, 16'h8001, 2'd2, 1'b1, 1'b1, acc);
        idle();
        tick(4);
        total++;
        if (!acc || cap.size() != 1) begin
            bad++; $display("FAIL single_count: accepted=%b writes=%0d required 1 1", acc, cap.size());
        end
        total++;
        if (cap.size() < 1) begin
            bad++; $display("FAIL single_entry: missing, required %h", exp);
        end else if (cap[0] !== exp) begin
            bad++; $display("FAIL single_entry: got %h required %h", cap[0], exp);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] e[4];
        ent_t exp[4];
        bit acc, all_acc;
        for (int i = 0; i < 4; i++) e[i] = mk_beat(32'h0400 + 32'(i));
        exp[0] = mk_ent({e[0], e[1][127:112]}, 16'h0001, 17'h00000, 2'd0, 1'b0, 1'b0);
        exp[1] = mk_ent({e[1], e[2][127:112]}, 16'h0002, 17'h00010, 2'd1, 1'b0, 1'b0);
        exp[2] = mk_ent({e[2], e[3][127:112]}, 16'h0003, 17'h00020, 2'd2, 1'b0, 1'b0);
        exp[3] = mk_ent({e[3], 16'h0000},      16'h0004, 17'h00030, 2'd3, 1'b0, 1'b1);
        cap.delete(); cap_cyc.delete();
        all_acc = 1'b1;
        drive_beat(e[0], 16'h0001, 2'd0, 1'b0, 1'b0, acc); all_acc &= acc;
        drive_beat(e[1], 16'h0002, 2'd1, 1'b0, 1'b0, acc); all_acc &= acc;
        // Stall in HOLD with the next beat already offered
        bus.q_almost_full = 1'b1;
        bus.in_data = e[2]; bus.in_position = 16'h0002; bus.in_garbage = 2'd2;
        bus.in_lit_flag = 1'b0; bus.in_last = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL hold_stall_ready: in_ready=%b required 0", bus.in_ready);
        end
        tick(3);
        total++;
        if (cap.size() != 1) begin
            bad++; $display("FAIL hold_stall_writes: writes=%0d required 1", cap.size());
        end
        bus.q_almost_full = 1'b0;
        drive_beat(e[2], 16'h0003, 2'd2, 1'b0, 1'b0, acc); all_acc &= acc;
        drive_beat(e[3], 16'h0004, 2'd3, 1'b0, 1'b1, acc); all_acc &= acc;
        // Stall in FLUSH: the final entry must wait for the queue
        bus.q_almost_full = 1'b1;
        idle();
        tick(3);
        total++;
        if (cap.size() != 3 || stray_done != 0) begin
            bad++; $display("FAIL flush_stall_writes: writes=%0d stray_done=%0d required 3 0", cap.size(), stray_done);
        end
        bus.q_almost_full = 1'b0;
        tick(3);
        total++;
        if (!all_acc || cap.size() != 4) begin
            bad++; $display("FAIL bp_count: accepted=%b writes=%0d required 1 4", all_acc, cap.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= cap.size()) begin
                bad++; $display("FAIL bp_entry%0d: missing, required %h", i, exp[i]);
            end else if (cap[i] !== exp[i]) begin
                bad++; $display("FAIL bp_entry%0d: got %h required %h", i, cap[i], exp[i]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        int unsigned n_beats;
        int rejected;
        bit acc;
        ent_t exp_a, exp_b, exp_first;
        logic [127:0] b8191, b8192, b0, b1;
        n_beats = 8193;
        rejected = 0;
        cap.delete(); cap_cyc.delete();
        for (int unsigned k = 0; k < n_beats; k++) begin
            drive_beat(mk_beat(k), 16'(k * 40503), k[1:0], k[2], (k == n_beats - 1), acc);
            if (!acc) rejected++;
        end
        idle();
        tick(4);
        b0 = mk_beat(0); b1 = mk_beat(1);
        b8191 = mk_beat(8191); b8192 = mk_beat(8192);
        exp_first = mk_ent({b0, b1[127:112]}, 16'h0000, 17'h00000, 2'd0, 1'b0, 1'b0);
        exp_a = mk_ent({b8191, b8192[127:112]}, 16'(8191 * 40503), 17'h1FFF0, 2'd3, 1'b1, 1'b0);
        exp_b = mk_ent({b8192, 16'h0000}, 16'(8192 * 40503), 17'h00000, 2'd0, 1'b0, 1'b1);
        total++;
        if (rejected != 0 || cap.size() != 8193) begin
            bad++; $display("FAIL wrap_count: rejected=%0d writes=%0d required 0 8193", rejected, cap.size());
        end
        total++;
        if (cap.size() < 1) begin
            bad++; $display("FAIL wrap_entry0: missing, required %h", exp_first);
        end else if (cap[0] !== exp_first) begin
            bad++; $display("FAIL wrap_entry0: got %h required %h", cap[0], exp_first);
        end
        total++;
        if (cap.size() < 8192) begin
            bad++; $display("FAIL wrap_entry8191: missing, required %h", exp_a);
        end else if (cap[8191] !== exp_a) begin
            bad++; $display("FAIL wrap_entry8191: got %h required %h", cap[8191], exp_a);
        end
        total++;
        if (cap.size() < 8193) begin
            bad++; $display("FAIL wrap_entry8192: missing, required %h", exp_b);
        end else if (cap[8192] !== exp_b) begin
            bad++; $display("FAIL wrap_entry8192: got %h required %h", cap[8192], exp_b);
        end
    endtask

    task automatic test_midstream_reset();
        logic [127:0] g0, g1, g2, h0, h1;
        ent_t exp0, exp1, exp2;
        bit acc, all_acc;
        g0 = mk_beat(32'h0500); g1 = mk_beat(32'h0501); g2 = mk_beat(32'h0502);
        h0 = mk_beat(32'h0600); h1 = mk_beat(32'h0601);
        exp0 = mk_ent({g0, g1[127:112]}, 16'h1111, 17'h00000, 2'd1, 1'b1, 1'b0);
        exp1 = mk_ent({h0, h1[127:112]}, 16'h3333, 17'h00000, 2'd3, 1'b0, 1'b0);
        exp2 = mk_ent({h1, 16'h0000},    16'h4444, 17'h00010, 2'd0, 1'b1, 1'b1);
        cap.delete(); cap_cyc.delete();
        all_acc = 1'b1;
        drive_beat(g0, 16'h1111, 2'd1, 1'b1, 1'b0, acc); all_acc &= acc;
        drive_beat(g1, 16'h2222, 2'd2, 1'b0, 1'b0, acc); all_acc &= acc;
        // Reset with the third beat on offer
        rst = 1'b1;
        bus.in_data = g2; bus.in_position = 16'h5555; bus.in_last = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL midrst_ready: in_ready=%b required 0", bus.in_ready);
        end
        tick(1);
        rst = 1'b0;
        idle();
        tick(5);
        total++;
        if (!all_acc || cap.size() != 1 || stray_done != 0) begin
            bad++; $display("FAIL midrst_no_write: accepted=%b writes=%0d stray_done=%0d required 1 1 0", all_acc, cap.size(), stray_done);
        end
        total++;
        if (cap.size() >= 1 && cap[0] !== exp0) begin
            bad++; $display("FAIL midrst_entry0: got %h required %h", cap[0], exp0);
        end
        cap.delete(); cap_cyc.delete();
        drive_beat(h0, 16'h3333, 2'd3, 1'b0, 1'b0, acc); all_acc &= acc;
        drive_beat(h1, 16'h4444, 2'd0, 1'b1, 1'b1, acc); all_acc &= acc;
        idle();
        tick(4);
        total++;
        if (cap.size() != 2) begin
            bad++; $display("FAIL midrst_next_count: writes=%0d required 2", cap.size());
        end else if (cap[0] !== exp1 || cap[1] !== exp2) begin
            bad++; $display("FAIL midrst_next_entries: got %h %h required %h %h", cap[0], cap[1], exp1, exp2);
        end
    endtask

`ifdef TOKEN_WR_COUNT_EN
    task automatic test_wr_count();
        bit acc;
        rst = 1'b1;
        idle();
        tick(1);
        rst = 1'b0;
        tick(1);
        total++;
        if (wr_count !== 32'd0) begin
            bad++; $display("FAIL wr_count_reset: wr_count=%0d required 0", wr_count);
        end
        for (int i = 0; i < 3; i++) drive_beat(mk_beat(32'h0700 + 32'(i)), 16'h0, 2'd0, 1'b0, (i == 2), acc);
        idle();
        tick(3);
        for (int i = 0; i < 2; i++) drive_beat(mk_beat(32'h0800 + 32'(i)), 16'h0, 2'd0, 1'b0, (i == 1), acc);
        idle();
        tick(4);
        total++;
        if (wr_count !== 32'd5) begin
            bad++; $display("FAIL wr_count_two_streams: wr_count=%0d required 5", wr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_three_beats();
        test_single_beat();
        test_backpressure();
        test_addr_wrap();
        test_midstream_reset();
`ifdef TOKEN_WR_COUNT_EN
        test_wr_count();
`endif
        total++;
        if (stray_done != 0) begin
            bad++; $display("FAIL stray_done: count=%0d required 0", stray_done);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/token_queue_writer.md
Name: token_queue_writer

Overview:
Producer side of the token queue. Accepts 16-byte compressed-data beats from the parser front end, each carrying a precomputed token-start mask, garbage count and literal flag. Appends a 2-byte lookahead taken from the following beat, so tokens straddling a beat boundary are fully visible. Tags each entry with a running byte address and writes it into the token queue under prog-full backpressure.

Parameters:
BEAT_BYTES, 16, bytes per input beat; fixed, because the entry format is 16+2 bytes.
ADDR_W, 17, width of the address field.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset; synchronous, active-high.
in_data  in  128  beat data; byte 0 at [127:120], byte 15 at [7:0].
in_position  in  16  token-start mask; bit 15 = byte 0.
in_garbage  in  2  garbage count for this beat, passed through unchanged.
in_lit_flag  in  1  beat starts inside literal content.
in_last  in  1  final beat of the stream.
in_valid  in  1  beat valid.
in_ready  out  1  beat accepted when in_valid & in_ready.
q_wrreq  out  1  queue write strobe.
q_data  out  144  {16 beat bytes, 2 lookahead bytes}.
q_position  out  16  mask of the emitted beat.
q_address  out  17  byte address of the emitted beat's byte 0.
q_garbage  out  2  garbage count of the emitted beat.
q_lit_flag  out  1  literal flag of the emitted beat.
q_almost_full  in  1  queue prog_full.
done  out  1  one-cycle pulse after the final entry of a stream is written.

Behaviour:
- Reset values:
  - q_wrreq=0, done=0, all q_* data fields 0.
  - in_ready=0 during the reset cycle.
  - Address counter 0; state EMPTY; pending register invalid.
- A reset asserted mid-stream discards the pending beat and the address with no further writes.
- State machine:
  - EMPTY: no pending beat. On accept:
    - latch the beat as pending with pending_addr = addr_cnt;
    - addr_cnt += 16;
    - go to HOLD, or to FLUSH if in_last.
  - HOLD: pending beat held. On accept, on the next cycle:
    - q_wrreq=1;
    - q_data = {pending[127:0], in_data[127:112]};
    - other q_* fields from the pending beat, q_address = pending_addr.
    - The accepted beat becomes the new pending beat; stay in HOLD, or go to FLUSH if in_last.
  - FLUSH: the last beat is pending and no further beat is accepted.
    - When q_almost_full=0, write pending with lookahead bytes 0x0000.
    - Next cycle: q_wrreq=1 and done=1 in the same cycle.
    - addr_cnt returns to 0; state returns to EMPTY.
- in_ready = ~rst & ~q_almost_full & (state != FLUSH).
- Outputs are registered: an entry appears one cycle after the accept or flush decision that produced it.
- q_wrreq is high for exactly one cycle per entry. Back-to-back accepts give back-to-back writes.
- Entry count per stream = beats per stream. Ordering is strictly preserved.
- q_almost_full sampled high stalls input immediately. At most one write is already in flight, so the queue prog_full threshold reserves at least 2 free entries.
- Address arithmetic is modulo 2^17: after 0x1FFF0 the next beat gets 0x00000.
- Simultaneous in_valid with q_almost_full=1: no accept, no state change.
- in_last on a beat accepted in EMPTY (a single-beat stream) goes directly to FLUSH.

Optional Feature:
TOKEN_WR_COUNT_EN: adds output wr_count[31:0].
- Increments on every q_wrreq and saturates at 0xFFFFFFFF.
- Cleared by rst only; not cleared between streams.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Three beats A,B,C (C last), q_almost_full=0:
  - entries {A,B[127:112]}@0x00000, {B,C[127:112]}@0x00010, {C,0x0000}@0x00020;
  - done pulses together with the third q_wrreq.
- Single beat D with in_last=1 and in_position=0x8001 → one entry {D,0x0000}, q_position=0x8001, q_address=0, done=1.
- Raise q_almost_full while in HOLD:
  - in_ready drops the same cycle and no further accept occurs;
  - at most one q_wrreq follows;
  - release resumes with no lost or duplicated entry.
- Stream of 8193 beats:
  - entry 8191 has q_address=0x1FFF0;
  - entry 8192 has q_address=0x00000 with correct lookahead data.
- Assert rst after two of four beats → no q_wrreq or done afterwards; the next stream's first entry has q_address=0.
- With TOKEN_WR_COUNT_EN: two streams of 3 and 2 beats → wr_count=5.
